// File: rtl/add4_share_ctrl.sv
//------------------------------------------------------------------------------
// Module   : add4_share_ctrl
// Brief    : Round-robin arbiter/sequencer sharing one add4 datapath between
//            two requesters; returns the registered sum tagged with owner id.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module add4_share_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0,
    input  logic [4*WIDTH-1:0] ops0,
    input  logic               req1,
    input  logic [4*WIDTH-1:0] ops1,
    output logic               gnt0,
    output logic               gnt1,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    output logic [WIDTH-1:0]   add_c,
    output logic [WIDTH-1:0]   add_d,
    input  logic [WIDTH-1:0]   add_sum,
    input  logic               add_ov,
    output logic [WIDTH-1:0]   res_sum,
    output logic               res_ov,
    output logic               res_id,
    output logic               res_valid,
    output logic               busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    state_t             r_state;
    logic               r_rr;
    logic               r_win;
    logic [4*WIDTH-1:0] r_ops;
    logic               w_win;
    logic [4*WIDTH-1:0] w_ops;

    // Round-robin pointer only breaks ties; a lone request always wins.
    always_comb begin
        w_win = (req0 & req1) ? r_rr : req1;
        w_ops = w_win ? ops1 : ops0;
    end

    assign add_a = r_ops[0*WIDTH +: WIDTH];
    assign add_b = r_ops[1*WIDTH +: WIDTH];
    assign add_c = r_ops[2*WIDTH +: WIDTH];
    assign add_d = r_ops[3*WIDTH +: WIDTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_rr      <= 1'b0;
            r_win     <= 1'b0;
            r_ops     <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            res_sum   <= '0;
            res_ov    <= 1'b0;
            res_id    <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            res_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req0 | req1) begin
                        r_ops   <= w_ops;
                        r_win   <= w_win;
                        gnt0    <= ~w_win;
                        gnt1    <= w_win;
                        busy    <= 1'b1;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Adder has settled from r_ops during this cycle.
                    res_sum   <= add_sum;
                    res_ov    <= add_ov;
                    res_id    <= r_win;
                    res_valid <= 1'b1;
                    r_rr      <= ~r_win;
                    busy      <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_add4_share_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_add4_share_ctrl
// Brief    : Self-checking bench for add4_share_ctrl with attached add4 model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_add4_share_ctrl;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             req0, req1;
    logic [4*WIDTH-1:0] ops0, ops1;
    logic             gnt0, gnt1;
    logic [WIDTH-1:0] add_a, add_b, add_c, add_d;
    logic [WIDTH-1:0] add_sum;
    logic             add_ov;
    logic [WIDTH-1:0] res_sum;
    logic             res_ov, res_id, res_valid, busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic last_w;

    add4_share_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .ops0(ops0), .req1(req1), .ops1(ops1),
        .gnt0(gnt0), .gnt1(gnt1),
        .add_a(add_a), .add_b(add_b), .add_c(add_c), .add_d(add_d),
        .add_sum(add_sum), .add_ov(add_ov),
        .res_sum(res_sum), .res_ov(res_ov), .res_id(res_id),
        .res_valid(res_valid), .busy(busy)
    );

    // Shared add4 instance stand-in.
    assign {add_ov, add_sum} = (WIDTH+1)'(add_a + add_b + add_c + add_d);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] ref_add(input logic [15:0] o);
        int t;
        t = int'(o[3:0]) + int'(o[7:4]) + int'(o[11:8]) + int'(o[15:12]);
        return t[4:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"},   {30'b0, gnt1, gnt0}, 32'd0);
        chk({tag, "_busy"},  {31'b0, busy}, 32'd0);
        chk({tag, "_valid"}, {31'b0, res_valid}, 32'd0);
        chk({tag, "_ops"},   {16'b0, add_d, add_c, add_b, add_a}, 32'd0);
        chk({tag, "_res"},   {26'b0, res_id, res_ov, res_sum}, 32'd0);
    endtask

    // One full operation: sample edge, EXEC cycle, capture edge.
    task automatic run_op(input logic r0, input logic r1, input logic [15:0] o0,
                          input logic [15:0] o1, input logic [15:0] tamper, input bit hold);
        logic w;
        logic [15:0] wo;
        logic [4:0] e;
        req0 = r0; req1 = r1; ops0 = o0; ops1 = o1;
        w  = (r0 && r1) ? ~last_w : r1;
        wo = w ? o1 : o0;
        e  = ref_add(wo);
        @(posedge clk); #1;
        chk("grant", {30'b0, gnt1, gnt0}, w ? 32'd2 : 32'd1);
        chk("busy_exec", {31'b0, busy}, 32'd1);
        chk("valid_exec", {31'b0, res_valid}, 32'd0);
        chk("latched_ops", {16'b0, add_d, add_c, add_b, add_a}, {16'b0, wo});
        if (!hold) begin
            if (w) req1 = 1'b0; else req0 = 1'b0;
        end
        if (w) ops1 = tamper; else ops0 = tamper;
        @(posedge clk); #1;
        chk("res_valid", {31'b0, res_valid}, 32'd1);
        chk("gnt_clear", {30'b0, gnt1, gnt0}, 32'd0);
        chk("busy_idle", {31'b0, busy}, 32'd0);
        chk("res_sum", {28'b0, res_sum}, {28'b0, e[3:0]});
        chk("res_ov", {31'b0, res_ov}, {31'b0, e[4]});
        chk("res_id", {31'b0, res_id}, {31'b0, w});
        last_w = w;
    endtask

    initial begin
        logic [15:0] o;
        logic [3:0]  held_sum;
        rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
        ops0 = 16'($urandom); ops1 = 16'($urandom);
        last_w = 1'b1;

        repeat (3) begin
            @(posedge clk); #1;
            chk_zero("reset");
        end
        rst = 1'b1;
        run_op(1'b1, 1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
        chk("first_after_reset", {31'b0, res_id}, 32'd0);

        run_op(1'b1, 1'b0, 16'h1543, 16'($urandom), 16'($urandom), 1'b0);
        chk("ex_sum13", {28'b0, res_sum}, 32'd13);
        chk("ex_ov0", {31'b0, res_ov}, 32'd0);

        run_op(1'b0, 1'b1, 16'($urandom), 16'hFFFF, 16'($urandom), 1'b0);
        chk("ex_sum12", {28'b0, res_sum}, 32'd12);
        chk("ex_ov1", {31'b0, res_ov}, 32'd1);
        chk("ex_id1", {31'b0, res_id}, 32'd1);

        for (int i = 0; i < 4096; i++) begin
            o = {4'($urandom), 12'(i)};
            run_op(1'b1, 1'b0, o, 16'($urandom), 16'($urandom), 1'b0);
        end

        for (int k = 0; k < 20; k++)
            run_op(1'b1, 1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 1'b1);

        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                req0 = 1'b0; req1 = 1'b0;
                held_sum = res_sum;
                @(posedge clk); #1;
                chk("idle_gnt", {30'b0, gnt1, gnt0}, 32'd0);
                chk("idle_valid", {31'b0, res_valid}, 32'd0);
                chk("idle_hold", {28'b0, res_sum}, {28'b0, held_sum});
            end else begin
                case ($urandom_range(0, 2))
                    0: run_op(1'b1, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
                    1: run_op(1'b0, 1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
                    default: run_op(1'b1, 1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
                endcase
            end
        end

        run_op(1'b1, 1'b0, 16'h1543, 16'($urandom), 16'hFFFF, 1'b0);
        chk("stable_sum", {28'b0, res_sum}, 32'd13);
        chk("stable_ov", {31'b0, res_ov}, 32'd0);

        req0 = 1'b0; req1 = 1'b1; ops1 = 16'($urandom);
        @(posedge clk); #1;
        chk("midop_gnt1", {30'b0, gnt1, gnt0}, 32'd2);
        rst = 1'b0;
        #1;
        chk_zero("midop_async");
        @(posedge clk); #1;
        chk_zero("midop_held");
        req0 = 1'b1; req1 = 1'b1; rst = 1'b1; last_w = 1'b1;
        run_op(1'b1, 1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
        chk("midop_first0", {31'b0, res_id}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
